// File: rtl/fourteen_to_one_deserializer.sv
// fourteen_to_one_deserializer: rebuilds MSB-first serial frames framed by active-low ss into parallel words
module fourteen_to_one_deserializer #(
    parameter int WIDTH = 14,
    parameter int COUNT_BITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ss,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_output,
    output logic             data_ready,
    output logic             frame_error,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RECEIVE, HOLD} state_t;
    localparam logic [COUNT_BITS-1:0] LAST = COUNT_BITS'(WIDTH - 1);
    state_t state, state_n;
    logic [WIDTH-1:0] shift, shift_n, data_n;
    logic [COUNT_BITS-1:0] count, count_n;
    logic ss_prev, ss_fall, ready_n, error_n;
    assign ss_fall = ss_prev & ~ss;
    assign busy = state == RECEIVE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            count       <= '0;
            data_output <= '0;
            data_ready  <= 1'b0;
            frame_error <= 1'b0;
            ss_prev     <= 1'b0;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            count       <= count_n;
            data_output <= data_n;
            data_ready  <= ready_n;
            frame_error <= error_n;
            ss_prev     <= ss;
        end
    end
    // The shift register fills from the LSB; the first bit reaches the MSB on the final shift.
    always_comb begin
        state_n = state;
        shift_n = shift;
        count_n = count;
        data_n  = data_output;
        ready_n = 1'b0;
        error_n = 1'b0;
        unique case (state)
            IDLE: if (ss_fall) begin
                shift_n = WIDTH'(serial_in);
                count_n = COUNT_BITS'(1);
                state_n = RECEIVE;
            end
            RECEIVE: if (ss) begin
                shift_n = '0;
                count_n = '0;
                error_n = 1'b1;
                state_n = IDLE;
            end else if (count == LAST) begin
                data_n  = {shift[WIDTH-2:0], serial_in};
                ready_n = 1'b1;
                count_n = '0;
                state_n = HOLD;
            end else begin
                shift_n = {shift[WIDTH-2:0], serial_in};
                count_n = count + 1'b1;
            end
            HOLD: if (ss) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fourteen_to_one_deserializer.sv
// tb_fourteen_to_one_deserializer: directed frames with a queue-based scoreboard checking every output pulse
module tb_fourteen_to_one_deserializer;
    logic clock = 1'b0, reset = 1'b1, ss = 1'b1, serial_in = 1'b0;
    logic [13:0] data_output;
    logic data_ready, frame_error, busy;
    int passed = 0, total = 0, busy_cycles = 0, ready_count = 0;
    typedef struct {bit err; logic [13:0] word;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    fourteen_to_one_deserializer dut (
        .clock(clock), .reset(reset), .ss(ss), .serial_in(serial_in),
        .data_output(data_output), .data_ready(data_ready),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic flag(input string name);
        total++;
        $display("FAIL %s: pulse seen, none expected", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [13:0] w, input int nbits, input int extra);
        for (int i = 0; i < nbits; i++) begin
            ss = 1'b0;
            serial_in = w[13-i];
            tick();
        end
        for (int i = 0; i < extra; i++) begin
            ss = 1'b0;
            serial_in = 1'($urandom_range(0, 1));
            tick();
        end
        ss = 1'b1;
        serial_in = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every pulse must match the head of the expectation queue.
    always @(negedge clock) begin
        if (busy) busy_cycles++;
        if (data_ready) ready_count++;
        if (data_ready && frame_error) flag("pulse_overlap");
        else if (data_ready || frame_error) begin
            if (exp_q.size() == 0) flag(data_ready ? "unexpected_ready" : "unexpected_error");
            else begin
                e = exp_q.pop_front();
                check("pulse_kind_is_error", frame_error, e.err);
                check("data_output", data_output, e.word);
            end
        end
    end

    initial begin
        // 1: reset values, then ss held low through reset release
        #12;
        check("reset_data", data_output, 0);
        check("reset_busy", busy, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("idle_ready", data_ready, 0);
        check("idle_error", frame_error, 0);
        check("idle_busy", busy, 0);
        reset = 1'b1;
        ss = 1'b0;
        tick();
        reset = 1'b0;
        busy_cycles = 0;
        ready_count = 0;
        repeat (20) tick();
        check("ss_low_reset_busy", busy_cycles, 0);
        check("ss_low_reset_ready", ready_count, 0);
        ss = 1'b1;
        tick();
        // 2: single frame with exact timing
        exp_q.push_back('{1'b0, 14'h2A5C});
        busy_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            ss = 1'b0;
            serial_in = (14'h2A5C >> (13 - i)) & 1'b1;
            tick();
        end
        check("ready_after_14th", data_ready, 1);
        check("word_2a5c", data_output, 14'h2A5C);
        ss = 1'b1;
        tick();
        check("ready_one_cycle", data_ready, 0);
        check("busy_13_cycles", busy_cycles, 13);
        // 3: back-to-back frames
        exp_q.push_back('{1'b0, 14'h3FFF});
        send(14'h3FFF, 14, 0);
        exp_q.push_back('{1'b0, 14'h0001});
        send(14'h0001, 14, 0);
        check("b2b_last", data_output, 14'h0001);
        // 4: aborted frame keeps the previous word
        exp_q.push_back('{1'b0, 14'h1234});
        send(14'h1234, 14, 0);
        ready_count = 0;
        exp_q.push_back('{1'b1, 14'h1234});
        send(14'h0F0F, 7, 0);
        tick();
        check("abort_no_ready", ready_count, 0);
        check("abort_busy", busy, 0);
        check("abort_keeps_word", data_output, 14'h1234);
        exp_q.push_back('{1'b0, 14'h0AAA});
        send(14'h0AAA, 14, 0);
        // 5: overlong ss yields exactly one word
        ready_count = 0;
        exp_q.push_back('{1'b0, 14'h1555});
        send(14'h1555, 14, 6);
        repeat (3) tick();
        check("overlong_one_ready", ready_count, 1);
        check("overlong_word", data_output, 14'h1555);
        // 6: asynchronous reset mid-frame
        for (int i = 0; i < 9; i++) begin
            ss = 1'b0;
            serial_in = (14'h3333 >> (13 - i)) & 1'b1;
            tick();
        end
        check("midframe_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_data", data_output, 0);
        ss = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        exp_q.push_back('{1'b0, 14'h3333});
        send(14'h3333, 14, 0);
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
